// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with architectural HI/LO and optional overflow trap.
// Latency: 1 cycle EX->MEM for every field; HI/LO visible the cycle after the write edge.
// Backpressure: stall holds every register; flush loads a bubble and wins over stall.
//
// Optional feature macro: OVERFLOW_TRAP_EN. When it is defined, a signed add/sub
// overflow squashes the write enables and raises exc_ov/exc_pc for one cycle.
// When it is undefined, ex_overflow/ex_ovf_chk are ignored and exc_ov/exc_pc read 0.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   stall, flush       pipeline freeze / bubble insert
//   ex_*               EX-stage results and control bundle
//   mem_*              registered copy of the EX bundle for the MEM stage
//   hi, lo             architectural HI/LO registers
//   exc_ov, exc_pc     overflow exception pulse and faulting PC
module ex_mem_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_valid,
  input  logic [DW-1:0] ex_result,
  input  logic [DW-1:0] ex_result2,
  input  logic          ex_overflow,
  input  logic          ex_ovf_chk,
  input  logic [1:0]    ex_hilo_op,
  input  logic [DW-1:0] ex_rs_data,
  input  logic          ex_reg_wen,
  input  logic [4:0]    ex_reg_waddr,
  input  logic          ex_mem_wen,
  input  logic          ex_mem_ren,
  input  logic [DW-1:0] ex_mem_wdata,
  input  logic [DW-1:0] ex_pc,
  output logic          mem_valid,
  output logic [DW-1:0] mem_alu_result,
  output logic          mem_reg_wen,
  output logic [4:0]    mem_reg_waddr,
  output logic          mem_mem_wen,
  output logic          mem_mem_ren,
  output logic [DW-1:0] mem_mem_wdata,
  output logic [DW-1:0] mem_pc,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic          exc_ov,
  output logic [DW-1:0] exc_pc
);

  localparam logic [1:0] HILO_NONE = 2'b00;
  localparam logic [1:0] HILO_MTHI = 2'b01;
  localparam logic [1:0] HILO_MTLO = 2'b10;
  localparam logic [1:0] HILO_MDIV = 2'b11;

  logic          advance;
  logic          trap;

  logic          valid_q,   valid_d;
  logic [DW-1:0] result_q,  result_d;
  logic          reg_wen_q, reg_wen_d;
  logic [4:0]    waddr_q,   waddr_d;
  logic          mem_wen_q, mem_wen_d;
  logic          mem_ren_q, mem_ren_d;
  logic [DW-1:0] wdata_q,   wdata_d;
  logic [DW-1:0] pc_q,      pc_d;
  logic [DW-1:0] hi_q,      hi_d;
  logic [DW-1:0] lo_q,      lo_d;

  assign advance = !flush && !stall;

`ifdef OVERFLOW_TRAP_EN
  assign trap = ex_valid & ex_ovf_chk & ex_overflow;
`else
  // Overflow inputs are intentionally ignored in this build.
  logic unused_ovf;
  assign unused_ovf = ex_overflow ^ ex_ovf_chk;
  assign trap       = 1'b0;
`endif

  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    reg_wen_d = reg_wen_q;
    waddr_d   = waddr_q;
    mem_wen_d = mem_wen_q;
    mem_ren_d = mem_ren_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (flush) begin
      // Bubble: kill the side-effecting bits, leave the data fields alone.
      valid_d   = 1'b0;
      reg_wen_d = 1'b0;
      mem_wen_d = 1'b0;
      mem_ren_d = 1'b0;
    end else if (advance) begin
      valid_d   = ex_valid;
      result_d  = ex_result;
      // A trapping instruction still flows down as valid, but with no side effects.
      reg_wen_d = ex_valid & ex_reg_wen & ~trap;
      waddr_d   = ex_reg_waddr;
      mem_wen_d = ex_valid & ex_mem_wen & ~trap;
      mem_ren_d = ex_valid & ex_mem_ren & ~trap;
      wdata_d   = ex_mem_wdata;
      pc_d      = ex_pc;
      if (ex_valid) begin
        case (ex_hilo_op)
          HILO_MDIV: begin
            hi_d = ex_result2;
            lo_d = ex_result;
          end
          HILO_MTHI: hi_d = ex_rs_data;
          HILO_MTLO: lo_d = ex_rs_data;
          HILO_NONE: ;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      reg_wen_q <= 1'b0;
      waddr_q   <= '0;
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
      wdata_q   <= '0;
      pc_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      reg_wen_q <= reg_wen_d;
      waddr_q   <= waddr_d;
      mem_wen_q <= mem_wen_d;
      mem_ren_q <= mem_ren_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  logic          exc_ov_q, exc_ov_d;
  logic [DW-1:0] exc_pc_q, exc_pc_d;

  always_comb begin
    exc_ov_d = exc_ov_q;
    exc_pc_d = exc_pc_q;
    if (flush) begin
      exc_ov_d = 1'b0;
    end else if (advance) begin
      // One advance cycle high per trapping instruction; held across stalls.
      exc_ov_d = trap;
      if (trap) exc_pc_d = ex_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_ov_q <= 1'b0;
      exc_pc_q <= '0;
    end else begin
      exc_ov_q <= exc_ov_d;
      exc_pc_q <= exc_pc_d;
    end
  end

  assign exc_ov = exc_ov_q;
  assign exc_pc = exc_pc_q;
`else
  assign exc_ov = 1'b0;
  assign exc_pc = '0;
`endif

  assign mem_valid      = valid_q;
  assign mem_alu_result = result_q;
  assign mem_reg_wen    = reg_wen_q;
  assign mem_reg_waddr  = waddr_q;
  assign mem_mem_wen    = mem_wen_q;
  assign mem_mem_ren    = mem_ren_q;
  assign mem_mem_wdata  = wdata_q;
  assign mem_pc         = pc_q;
  assign hi             = hi_q;
  assign lo             = lo_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, HI/LO writes, stall, flush, overflow trap.
// Latency: checks sample 1ns after each rising edge.
// Backpressure: stall/flush driven directly as stimulus.
module tb_ex_mem_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall, flush;
  logic          ex_valid;
  logic [DW-1:0] ex_result, ex_result2;
  logic          ex_overflow, ex_ovf_chk;
  logic [1:0]    ex_hilo_op;
  logic [DW-1:0] ex_rs_data;
  logic          ex_reg_wen;
  logic [4:0]    ex_reg_waddr;
  logic          ex_mem_wen, ex_mem_ren;
  logic [DW-1:0] ex_mem_wdata, ex_pc;
  logic          mem_valid;
  logic [DW-1:0] mem_alu_result;
  logic          mem_reg_wen;
  logic [4:0]    mem_reg_waddr;
  logic          mem_mem_wen, mem_mem_ren;
  logic [DW-1:0] mem_mem_wdata, mem_pc;
  logic [DW-1:0] hi, lo;
  logic          exc_ov;
  logic [DW-1:0] exc_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_result2(ex_result2),
    .ex_overflow(ex_overflow), .ex_ovf_chk(ex_ovf_chk), .ex_hilo_op(ex_hilo_op),
    .ex_rs_data(ex_rs_data), .ex_reg_wen(ex_reg_wen), .ex_reg_waddr(ex_reg_waddr),
    .ex_mem_wen(ex_mem_wen), .ex_mem_ren(ex_mem_ren), .ex_mem_wdata(ex_mem_wdata),
    .ex_pc(ex_pc),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result), .mem_reg_wen(mem_reg_wen),
    .mem_reg_waddr(mem_reg_waddr), .mem_mem_wen(mem_mem_wen), .mem_mem_ren(mem_mem_ren),
    .mem_mem_wdata(mem_mem_wdata), .mem_pc(mem_pc), .hi(hi), .lo(lo),
    .exc_ov(exc_ov), .exc_pc(exc_pc)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [DW-1:0] r, input logic [DW-1:0] r2,
                           input logic [1:0] op, input logic [DW-1:0] rs, input logic rw,
                           input logic [4:0] wa, input logic mw, input logic mr,
                           input logic [DW-1:0] wd, input logic [DW-1:0] pc);
    ex_valid = v; ex_result = r; ex_result2 = r2; ex_hilo_op = op; ex_rs_data = rs;
    ex_reg_wen = rw; ex_reg_waddr = wa; ex_mem_wen = mw; ex_mem_ren = mr;
    ex_mem_wdata = wd; ex_pc = pc; ex_overflow = 1'b0; ex_ovf_chk = 1'b0;
  endtask

  initial begin
    // Reset with garbage on every input and no clock edge involved.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_instr(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 2'b11, 32'h1357_9BDF, 1'b1,
              5'd31, 1'b1, 1'b1, 32'h2468_ACE0, 32'hFFFF_FFFC);
    ex_overflow = 1'b1; ex_ovf_chk = 1'b1;
    #2;
    check("rst_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_result", mem_alu_result, 32'h0);
    check("rst_pc", mem_pc, 32'h0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_exc_ov", {31'b0, exc_ov}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after release: normal advance, MULT-style HI/LO write.
    set_instr(1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 2'b11, 32'h0, 1'b1,
              5'd7, 1'b1, 1'b1, 32'h0BAD_F00D, 32'h0000_0200);
    step();
    check("adv_valid", {31'b0, mem_valid}, 32'h1);
    check("adv_result", mem_alu_result, 32'hA5A5_A5A5);
    check("adv_waddr", {27'b0, mem_reg_waddr}, 32'd7);
    check("adv_enables", {29'b0, mem_reg_wen, mem_mem_wen, mem_mem_ren}, 32'h7);
    check("adv_wdata", mem_mem_wdata, 32'h0BAD_F00D);
    check("adv_pc", mem_pc, 32'h0000_0200);
    check("adv_hi", hi, 32'h5A5A_5A5A);
    check("adv_lo", lo, 32'hA5A5_A5A5);

    // Reset asserted mid-stall clears immediately.
    stall = 1'b1;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst_stall_valid", {31'b0, mem_valid}, 32'h0);
    check("rst_stall_result", mem_alu_result, 32'h0);
    check("rst_stall_hi", hi, 32'h0);
    check("rst_stall_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0;

    // MULT then MTLO then MTHI.
    set_instr(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 2'b11, 32'h0, 1'b0,
              5'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0300);
    step();
    check("mult_lo", lo, 32'h0000_0001);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    set_instr(1'b1, 32'h0, 32'h0, 2'b10, 32'h0000_1234, 1'b0,
              5'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0304);
    step();
    check("mtlo_lo", lo, 32'h0000_1234);
    check("mtlo_hi", hi, 32'hFFFF_FFFF);
    set_instr(1'b1, 32'h0, 32'h0, 2'b01, 32'h0000_BEEF, 1'b0,
              5'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0308);
    step();
    check("mthi_hi", hi, 32'h0000_BEEF);
    check("mthi_lo", lo, 32'h0000_1234);

    // Invalid EX slot: enables forced off, HI/LO untouched, data still captured.
    set_instr(1'b0, 32'h7777_7777, 32'h8888_8888, 2'b11, 32'h0, 1'b1,
              5'd9, 1'b1, 1'b1, 32'h0, 32'h0000_030C);
    step();
    check("inv_valid", {31'b0, mem_valid}, 32'h0);
    check("inv_enables", {29'b0, mem_reg_wen, mem_mem_wen, mem_mem_ren}, 32'h0);
    check("inv_result", mem_alu_result, 32'h7777_7777);
    check("inv_hi", hi, 32'h0000_BEEF);
    check("inv_lo", lo, 32'h0000_1234);

    // Known instruction, then 3 stall cycles with changing EX inputs.
    set_instr(1'b1, 32'h1111_1111, 32'h0, 2'b00, 32'h0, 1'b1,
              5'd3, 1'b0, 1'b0, 32'h0, 32'h0000_0100);
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 32'h2222_0000 + i, 32'h9999_0000 + i, 2'b11, 32'h4444_0000 + i, 1'b1,
                5'd20 + 5'(i), 1'b1, 1'b0, 32'h5555_0000 + i, 32'h0000_0500 + 32'(i));
      step();
      check("stall_result", mem_alu_result, 32'h1111_1111);
      check("stall_waddr", {27'b0, mem_reg_waddr}, 32'd3);
      check("stall_pc", mem_pc, 32'h0000_0100);
      check("stall_enables", {29'b0, mem_reg_wen, mem_mem_wen, mem_mem_ren}, 32'h4);
      check("stall_hi", hi, 32'h0000_BEEF);
      check("stall_lo", lo, 32'h0000_1234);
    end
    stall = 1'b0;
    step();
    check("unstall_result", mem_alu_result, 32'h2222_0002);
    check("unstall_waddr", {27'b0, mem_reg_waddr}, 32'd22);
    check("unstall_enables", {29'b0, mem_reg_wen, mem_mem_wen, mem_mem_ren}, 32'h6);
    check("unstall_hi", hi, 32'h9999_0002);
    check("unstall_lo", lo, 32'h2222_0002);

    // Flush and stall together with a valid DIV: bubble, HI/LO unchanged.
    stall = 1'b1; flush = 1'b1;
    set_instr(1'b1, 32'h0000_0003, 32'h0000_0001, 2'b11, 32'h0, 1'b1,
              5'd4, 1'b1, 1'b1, 32'h0, 32'h0000_0600);
    step();
    check("flush_valid", {31'b0, mem_valid}, 32'h0);
    check("flush_enables", {29'b0, mem_reg_wen, mem_mem_wen, mem_mem_ren}, 32'h0);
    check("flush_hi", hi, 32'h9999_0002);
    check("flush_lo", lo, 32'h2222_0002);
    stall = 1'b0; flush = 1'b0;

    // Signed ADD overflow 0x7FFFFFFF + 1.
    set_instr(1'b1, 32'h8000_0000, 32'h0, 2'b00, 32'h0, 1'b1,
              5'd8, 1'b0, 1'b0, 32'h0, 32'h0040_0010);
    ex_ovf_chk = 1'b1; ex_overflow = 1'b1;
    step();
    check("ovf_result", mem_alu_result, 32'h8000_0000);
    check("ovf_valid", {31'b0, mem_valid}, 32'h1);
`ifdef OVERFLOW_TRAP_EN
    check("ovf_reg_wen", {31'b0, mem_reg_wen}, 32'h0);
    check("ovf_exc_ov", {31'b0, exc_ov}, 32'h1);
    check("ovf_exc_pc", exc_pc, 32'h0040_0010);
    // Pending exception holds across a stall, then drops on the next advance.
    stall = 1'b1;
    set_instr(1'b1, 32'h0000_0042, 32'h0, 2'b00, 32'h0, 1'b1,
              5'd9, 1'b0, 1'b0, 32'h0, 32'h0040_0014);
    step();
    check("ovf_stall_exc_ov", {31'b0, exc_ov}, 32'h1);
    stall = 1'b0;
    step();
    check("ovf_next_exc_ov", {31'b0, exc_ov}, 32'h0);
    check("ovf_next_reg_wen", {31'b0, mem_reg_wen}, 32'h1);
`else
    check("ovf_reg_wen", {31'b0, mem_reg_wen}, 32'h1);
    check("ovf_exc_ov", {31'b0, exc_ov}, 32'h0);
    check("ovf_exc_pc", exc_pc, 32'h0);
`endif

    // Overflow flag on a non-trapping op (ADDU) never squashes.
    set_instr(1'b1, 32'h8000_0000, 32'h0, 2'b00, 32'h0, 1'b1,
              5'd10, 1'b1, 1'b0, 32'h0, 32'h0040_0020);
    ex_overflow = 1'b1; ex_ovf_chk = 1'b0;
    step();
    check("addu_enables", {29'b0, mem_reg_wen, mem_mem_wen, mem_mem_ren}, 32'h6);
    check("addu_exc_ov", {31'b0, exc_ov}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
